// File: rtl/cpu_seq_ctrl_if.sv
// Handshake and control bundle between the RV32I control sequencer and
// the rest of the core (instruction/data memory, decoder, ALU, PC, regfile).
interface cpu_seq_ctrl_if #(
   parameter int RETIRE_W = 32
);
   logic                imem_req;
   logic                imem_ready;
   logic [31:0]         imem_rdata;
   logic [31:0]         ir;
   logic                dec_en;
   logic [31:0]         invalid_instruction;
   logic [7:0]          mechie_op;
   logic                dmem_req;
   logic                dmem_we;
   logic                dmem_ready;
   logic                alu_valid;
   logic                rf_we;
   logic                pc_we;
   logic [1:0]          pc_sel;
   logic                br_taken;
   logic                trap;
   logic [3:0]          trap_cause;
   logic                irq;
   logic                halted;
   logic [RETIRE_W-1:0] retired;

   // Sequencer side: drives requests, strobes and status
   modport master (
      output imem_req, ir, dec_en, dmem_req, dmem_we, alu_valid, rf_we,
             pc_we, pc_sel, trap, trap_cause, halted, retired,
      input  imem_ready, imem_rdata, invalid_instruction, mechie_op,
             dmem_ready, br_taken, irq
   );

   // Surrounding core side: answers requests and reports decode results
   modport slave (
      input  imem_req, ir, dec_en, dmem_req, dmem_we, alu_valid, rf_we,
             pc_we, pc_sel, trap, trap_cause, halted, retired,
      output imem_ready, imem_rdata, invalid_instruction, mechie_op,
             dmem_ready, br_taken, irq
   );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the RV32I core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, with trap entry, WFI halt, memory
// timeouts and a retired-instruction counter.
module cpu_seq_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int RETIRE_W    = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   cpu_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_WFI
   } state_t;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_TARGET = 2'b01;
   localparam logic [1:0] PC_TRAP   = 2'b10;
   localparam logic [1:0] PC_MEPC   = 2'b11;

   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
   localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
   localparam logic [3:0] CAUSE_BUS     = 4'd5;
   localparam logic [3:0] CAUSE_ECALL   = 4'd11;

   // The last waiting cycle before a request gives up with a bus error
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [31:0]         ir_q, ir_d;
   logic [RETIRE_W-1:0] retired_q;
   logic [3:0]          cause_q, cause_d;
   logic [7:0]          tmo_q;
   logic [1:0]          pc_sel_q, pc_sel_d;
   logic                trap_retire_q, trap_retire_d;
   logic                retire_inc;

   logic                imem_req, dec_en, dmem_req, dmem_we, alu_valid;
   logic                rf_we, pc_we, trap, halted;
   logic [1:0]          pc_sel;

   logic [4:0]          opcode;
   logic                is_store, is_mem, is_branch, is_jump, rd_zero;

   assign opcode    = ir_q[6:2];
   assign is_store  = (opcode == OP_STORE);
   assign is_mem    = (opcode == OP_LOAD) || is_store;
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign rd_zero   = (ir_q[11:7] == 5'd0);

   // State register plus IR, trap cause, PC decision, timeout and retire count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_FETCH;
         ir_q          <= '0;
         retired_q     <= '0;
         cause_q       <= '0;
         tmo_q         <= '0;
         pc_sel_q      <= PC_NEXT;
         trap_retire_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         cause_q       <= cause_d;
         pc_sel_q      <= pc_sel_d;
         trap_retire_q <= trap_retire_d;
         retired_q     <= retired_q + RETIRE_W'(retire_inc);
         if (state_d != state_q) begin
            tmo_q <= '0;
         end else if (state_q == S_FETCH || state_q == S_MEM) begin
            tmo_q <= tmo_q + 8'd1;
         end
      end
   end

   // Next-state decision and per-state strobes; everything is forced low while reset is held
   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      cause_d       = cause_q;
      pc_sel_d      = pc_sel_q;
      trap_retire_d = trap_retire_q;
      retire_inc    = 1'b0;
      imem_req      = 1'b0;
      dec_en        = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      alu_valid     = 1'b0;
      rf_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = PC_NEXT;
      trap          = 1'b0;
      halted        = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ready) begin
               ir_d    = bus.imem_rdata;
               state_d = S_DECODE;
            end else if (tmo_q == TMO_LAST) begin
               cause_d       = CAUSE_BUS;
               trap_retire_d = 1'b0;
               state_d       = S_TRAP;
            end
         end
         S_DECODE: begin
            dec_en = 1'b1;
            if (ir_q[1:0] != 2'b11 || bus.invalid_instruction == 32'd2) begin
               cause_d       = CAUSE_ILLEGAL;
               trap_retire_d = 1'b0;
               state_d       = S_TRAP;
            end else if (bus.mechie_op[0]) begin
               cause_d       = CAUSE_EBREAK;
               trap_retire_d = 1'b1;
               state_d       = S_TRAP;
            end else if (bus.mechie_op[1]) begin
               cause_d       = CAUSE_ECALL;
               trap_retire_d = 1'b1;
               state_d       = S_TRAP;
            end else if (bus.mechie_op[5]) begin
               state_d = S_WFI;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            dec_en    = 1'b1;
            alu_valid = 1'b1;
            pc_sel_d  = PC_NEXT;
            if (is_mem) begin
               state_d = S_MEM;
            end else begin
               if (is_jump || (is_branch && bus.br_taken)) begin
                  pc_sel_d = PC_TARGET;
               end else if (bus.mechie_op[2]) begin
                  pc_sel_d = PC_MEPC;
               end
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dec_en   = 1'b1;
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (bus.dmem_ready) begin
               state_d = S_WB;
            end else if (tmo_q == TMO_LAST) begin
               cause_d       = CAUSE_BUS;
               trap_retire_d = 1'b0;
               state_d       = S_TRAP;
            end
         end
         S_WB: begin
            dec_en     = 1'b1;
            pc_we      = 1'b1;
            pc_sel     = pc_sel_q;
            rf_we      = !(is_store || is_branch || bus.mechie_op[2] || rd_zero);
            retire_inc = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: begin
            trap       = 1'b1;
            pc_we      = 1'b1;
            pc_sel     = PC_TRAP;
            retire_inc = trap_retire_q;
            state_d    = S_FETCH;
         end
         S_WFI: begin
            halted = 1'b1;
            if (bus.irq) begin
               pc_we      = 1'b1;
               pc_sel     = PC_NEXT;
               retire_inc = 1'b1;
               state_d    = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (!rst_n) begin
         imem_req  = 1'b0;
         dec_en    = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         alu_valid = 1'b0;
         rf_we     = 1'b0;
         pc_we     = 1'b0;
         pc_sel    = PC_NEXT;
         trap      = 1'b0;
         halted    = 1'b0;
      end
   end

   assign bus.imem_req   = imem_req;
   assign bus.ir         = ir_q;
   assign bus.dec_en     = dec_en;
   assign bus.dmem_req   = dmem_req;
   assign bus.dmem_we    = dmem_we;
   assign bus.alu_valid  = alu_valid;
   assign bus.rf_we      = rf_we;
   assign bus.pc_we      = pc_we;
   assign bus.pc_sel     = pc_sel;
   assign bus.trap       = trap;
   assign bus.trap_cause = cause_q;
   assign bus.halted     = halted;
   assign bus.retired    = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed cases followed by random
// instruction streams, each judged against a per-instruction outcome model.
module tb_cpu_seq_ctrl;

   localparam int T  = 4;
   localparam int RW = 8;

   logic clk;
   logic rst_n;

   cpu_seq_ctrl_if #(.RETIRE_W(RW)) bus ();

   cpu_seq_ctrl #(.MEM_TIMEOUT(T), .RETIRE_W(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [RW-1:0] exp_retired;
   logic [3:0]    exp_cause;

   // Free-running clock
   always #5 clk = ~clk;

   // Stand-in for the instruction decoder: recognises the known opcode classes and machine ops
   always_comb begin
      bus.invalid_instruction = 32'd0;
      bus.mechie_op           = 8'd0;
      case (bus.ir[6:2])
         5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
         5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b00011: ;
         5'b11100: begin
            if      (bus.ir == 32'h00100073) bus.mechie_op[0] = 1'b1;
            else if (bus.ir == 32'h00000073) bus.mechie_op[1] = 1'b1;
            else if (bus.ir == 32'h30200073) bus.mechie_op[2] = 1'b1;
            else if (bus.ir == 32'h10500073) bus.mechie_op[5] = 1'b1;
            else bus.invalid_instruction = 32'd2;
         end
         default: bus.invalid_instruction = 32'd2;
      endcase
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Build a random instruction from one of the classes the sequencer distinguishes
   function automatic logic [31:0] randomInstr();
      logic [31:0] r;
      int k;
      r = $urandom();
      k = $urandom_range(0, 13);
      case (k)
         0:  r[6:0] = 7'b0010011;
         1:  r[6:0] = 7'b0110011;
         2:  r[6:0] = 7'b0110111;
         3:  r[6:0] = 7'b0000011;
         4:  r[6:0] = 7'b0100011;
         5:  r[6:0] = 7'b1100011;
         6:  r[6:0] = 7'b1101111;
         7:  r[6:0] = 7'b1100111;
         8:  r = 32'h00000073;
         9:  r = 32'h00100073;
         10: r = 32'h30200073;
         11: r = 32'h10500073;
         12: r[1:0] = 2'b01;
         default: r[6:0] = 7'b1111111;
      endcase
      if (k <= 7 && $urandom_range(0, 3) == 0) r[11:7] = 5'd0;
      return r;
   endfunction

   // Run one instruction with the given memory/irq wait profile and check its whole outcome
   task automatic applyStimulus(input logic [31:0] instr, input int fetch_wait,
                                input int mem_wait, input int irq_wait, input logic br);
      logic [4:0] op5;
      bit known, is_ecall, is_ebreak, is_mret, is_wfi, is_load, is_store, is_branch, is_jump, rd0;
      bit e_trap, e_rfwe, e_ret, e_we, check_lat;
      logic [1:0] e_pcsel;
      int e_alu, e_imem, e_dmem, e_halt, e_lat;
      int fw, mw, hw, alu_cnt, imem_cnt, dmem_cnt, halt_cnt, we_bad, accept_cyc, lat;
      bit seen;
      logic [1:0] g_pcsel;
      logic g_rfwe, g_trap;
      logic [3:0] g_cause;

      op5       = instr[6:2];
      is_ecall  = (instr == 32'h00000073);
      is_ebreak = (instr == 32'h00100073);
      is_mret   = (instr == 32'h30200073);
      is_wfi    = (instr == 32'h10500073);
      is_load   = (op5 == 5'b00000);
      is_store  = (op5 == 5'b01000);
      is_branch = (op5 == 5'b11000);
      is_jump   = (op5 == 5'b11011) || (op5 == 5'b11001);
      rd0       = (instr[11:7] == 5'd0);
      known     = is_load || is_store || is_branch || is_jump ||
                  op5 inside {5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b00011} ||
                  is_ecall || is_ebreak || is_mret || is_wfi;

      e_imem = (fetch_wait >= T) ? T : fetch_wait + 1;
      e_alu = 0; e_dmem = 0; e_halt = 0; e_lat = 0;
      e_trap = 0; e_pcsel = 2'd0; e_rfwe = 0; e_ret = 1; check_lat = 1;
      e_we = is_store;
      if (fetch_wait >= T) begin
         e_trap = 1; exp_cause = 4'd5; e_ret = 0; check_lat = 0;
      end else if (instr[1:0] != 2'b11 || !known) begin
         e_trap = 1; exp_cause = 4'd2; e_ret = 0; e_lat = 2;
      end else if (is_ebreak) begin
         e_trap = 1; exp_cause = 4'd3; e_lat = 2;
      end else if (is_ecall) begin
         e_trap = 1; exp_cause = 4'd11; e_lat = 2;
      end else if (is_wfi) begin
         e_halt = irq_wait + 1; e_lat = 2 + irq_wait;
      end else begin
         e_alu = 1;
         if (is_load || is_store) begin
            if (mem_wait >= T) begin
               e_dmem = T; e_trap = 1; exp_cause = 4'd5; e_ret = 0; e_lat = 3 + T;
            end else begin
               e_dmem = mem_wait + 1; e_lat = 4 + mem_wait;
               e_rfwe = !is_store && !rd0;
            end
         end else begin
            e_lat  = 3;
            e_rfwe = !(is_branch || is_mret) && !rd0;
            if (is_jump || (is_branch && br)) e_pcsel = 2'd1;
            else if (is_mret)                  e_pcsel = 2'd3;
         end
      end
      if (e_trap) begin
         e_pcsel = 2'd2; e_rfwe = 0;
      end
      if (e_ret) exp_retired = exp_retired + 1'b1;

      fw = 0; mw = 0; hw = 0; alu_cnt = 0; imem_cnt = 0; dmem_cnt = 0; halt_cnt = 0;
      we_bad = 0; accept_cyc = -1; lat = 0; seen = 0;
      g_pcsel = 0; g_rfwe = 0; g_trap = 0; g_cause = 0;
      bus.br_taken = br;
      for (int cyc = 0; cyc < 64 && !seen; cyc++) begin
         bus.imem_ready = 1'b0;
         bus.imem_rdata = $urandom();
         bus.dmem_ready = 1'b0;
         bus.irq        = 1'b0;
         if (bus.imem_req) begin
            imem_cnt++;
            if (fw == fetch_wait) begin
               bus.imem_ready = 1'b1;
               bus.imem_rdata = instr;
               accept_cyc     = cyc;
            end
            fw++;
         end
         if (bus.dmem_req) begin
            dmem_cnt++;
            if (bus.dmem_we !== e_we) we_bad++;
            if (mw == mem_wait) bus.dmem_ready = 1'b1;
            mw++;
         end
         if (bus.halted) begin
            halt_cnt++;
            if (hw == irq_wait) bus.irq = 1'b1;
            hw++;
         end
         #1;
         if (bus.alu_valid) alu_cnt++;
         if (bus.pc_we) begin
            seen    = 1;
            g_pcsel = bus.pc_sel;
            g_rfwe  = bus.rf_we;
            g_trap  = bus.trap;
            g_cause = bus.trap_cause;
            lat     = cyc - accept_cyc;
         end else begin
            @(negedge clk);
         end
      end

      checkOutput("pc_we_seen", 32'(seen), 32'd1);
      checkOutput("pc_sel", 32'(g_pcsel), 32'(e_pcsel));
      checkOutput("rf_we", 32'(g_rfwe), 32'(e_rfwe));
      checkOutput("trap", 32'(g_trap), 32'(e_trap));
      checkOutput("trap_cause", 32'(g_cause), 32'(exp_cause));
      checkOutput("alu_valid_cycles", 32'(alu_cnt), 32'(e_alu));
      checkOutput("imem_req_cycles", 32'(imem_cnt), 32'(e_imem));
      checkOutput("dmem_req_cycles", 32'(dmem_cnt), 32'(e_dmem));
      checkOutput("dmem_we_bad", 32'(we_bad), 32'd0);
      checkOutput("halted_cycles", 32'(halt_cnt), 32'(e_halt));
      if (check_lat) checkOutput("latency", 32'(lat), 32'(e_lat));

      @(negedge clk);
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.irq        = 1'b0;
      checkOutput("retired", 32'(bus.retired), 32'(exp_retired));
   endtask

   // Start a load and pull reset while its data request is outstanding
   task automatic resetMidMem();
      int n;
      n = 0;
      bus.br_taken   = 1'b0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'h0000A103;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      while (!bus.dmem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rst_dmem_req_before", 32'(bus.dmem_req), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
      checkOutput("rst_retired", 32'(bus.retired), 32'd0);
      checkOutput("rst_strobes", 32'({bus.dmem_we, bus.alu_valid, bus.rf_we, bus.pc_we,
                                      bus.trap, bus.halted, bus.dec_en}), 32'd0);
      checkOutput("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
      checkOutput("rst_trap_cause", 32'(bus.trap_cause), 32'd0);
      checkOutput("rst_ir", bus.ir, 32'd0);
      exp_retired = '0;
      exp_cause   = '0;
      rst_n = 1'b1;
      #1;
      checkOutput("rst_release_fetch", 32'(bus.imem_req), 32'd1);
   endtask

   // Main sequence: reset, directed cases, random stream, reset mid-access, more random
   initial begin
      clk            = 1'b0;
      rst_n          = 1'b0;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      bus.dmem_ready = 1'b0;
      bus.br_taken   = 1'b0;
      bus.irq        = 1'b0;
      exp_retired    = '0;
      exp_cause      = '0;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_imem_req", 32'(bus.imem_req), 32'd0);
      checkOutput("reset_retired", 32'(bus.retired), 32'd0);
      checkOutput("reset_ir", bus.ir, 32'd0);
      checkOutput("reset_strobes", 32'({bus.dmem_req, bus.dmem_we, bus.alu_valid, bus.rf_we,
                                        bus.pc_we, bus.trap, bus.halted, bus.dec_en}), 32'd0);
      checkOutput("reset_pc_sel", 32'(bus.pc_sel), 32'd0);
      checkOutput("reset_trap_cause", 32'(bus.trap_cause), 32'd0);
      rst_n = 1'b1;
      #1;

      applyStimulus(32'h00100093, 0, 0, 0, 1'b0);
      applyStimulus(32'h0020A023, 0, 3, 0, 1'b0);
      applyStimulus(32'h00000063, 0, 0, 0, 1'b1);
      applyStimulus(32'h00000063, 0, 0, 0, 1'b0);
      applyStimulus(32'h00000000, 0, 0, 0, 1'b0);
      applyStimulus(32'h00000073, 0, 0, 0, 1'b0);
      applyStimulus(32'h00100073, 1, 0, 0, 1'b0);
      applyStimulus(32'h00100093, T, 0, 0, 1'b0);
      applyStimulus(32'h00100093, T - 1, 0, 0, 1'b0);
      applyStimulus(32'h0000A103, 0, T - 1, 0, 1'b0);
      applyStimulus(32'h0000A103, 0, T, 0, 1'b0);
      applyStimulus(32'h10500073, 0, 0, 3, 1'b0);
      applyStimulus(32'h30200073, 0, 0, 0, 1'b0);
      applyStimulus(32'h008000EF, 0, 0, 0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(randomInstr(), $urandom_range(0, T + 1), $urandom_range(0, T + 1),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      resetMidMem();

      for (int i = 0; i < 40; i++) begin
         applyStimulus(randomInstr(), $urandom_range(0, T), $urandom_range(0, T),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
